// File: rtl/alu_host_driver_if.sv
// Command/response handshake bundle between a host and alu_host_driver.
interface alu_host_driver_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic [3:0] cmd_sel;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_result;
  logic [3:0] rsp_flags;

  modport master (output cmd_valid, cmd_a, cmd_b, cmd_sel, rsp_ready,
                  input  cmd_ready, rsp_valid, rsp_result, rsp_flags);
  modport slave  (input  cmd_valid, cmd_a, cmd_b, cmd_sel, rsp_ready,
                  output cmd_ready, rsp_valid, rsp_result, rsp_flags);
endinterface

// File: rtl/alu_host_driver.sv
// Host-side driver for the 4-bit ALU pin interface: drives operands onto the
// ALU pins, waits a settle time, samples uo_out and returns it as a response.
module alu_host_driver #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  alu_host_driver_if.slave host,
  output logic [7:0]       pin_ui_out,
  output logic [7:0]       pin_uio_out,
  output logic [7:0]       pin_uio_oe,
  input  logic [7:0]       pin_uo_in,
  output logic             busy,
  output logic [CNT_W-1:0] cmd_count
);
  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;
  typedef struct packed {
    logic [3:0] flags;
    logic [3:0] result;
  } rsp_t;

  // Counter runs SETTLE_CYCLES-1 .. 0, capture happens on the edge that sees 0.
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  state_t     state, state_nxt;
  logic [7:0] settle_cnt;
  rsp_t       rsp_q;
  logic       cmd_fire, capture, rsp_fire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_fire  = 1'b0;
    capture   = 1'b0;
    rsp_fire  = 1'b0;
    case (state)
      IDLE: if (host.cmd_valid) begin
        cmd_fire  = 1'b1;
        state_nxt = SETTLE;
      end
      SETTLE: if (settle_cnt == '0) begin
        capture   = 1'b1;
        state_nxt = RESP;
      end
      RESP: if (host.rsp_ready) begin
        rsp_fire  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle_cnt  <= '0;
      rsp_q       <= '0;
      pin_ui_out  <= '0;
      pin_uio_out <= '0;
      pin_uio_oe  <= '0;
      cmd_count   <= '0;
    end else begin
      // Only the low uio nibble (sel) is ever driven by the host.
      pin_uio_oe <= 8'h0F;
      if (cmd_fire) begin
        pin_ui_out  <= {host.cmd_b, host.cmd_a};
        pin_uio_out <= {4'b0000, host.cmd_sel};
        settle_cnt  <= SETTLE_LOAD;
      end else if (state == SETTLE && settle_cnt != '0) begin
        settle_cnt <= settle_cnt - 8'd1;
      end
      if (capture)  rsp_q     <= rsp_t'(pin_uo_in);
      if (rsp_fire) cmd_count <= cmd_count + CNT_W'(1);
    end
  end

  // rsp_valid follows the state so an async reset drops it immediately.
  assign host.cmd_ready  = (state == IDLE);
  assign host.rsp_valid  = (state == RESP);
  assign host.rsp_result = rsp_q.result;
  assign host.rsp_flags  = rsp_q.flags;
  assign busy            = (state != IDLE);
endmodule

// File: tb/tb_alu_host_driver.sv
// Scoreboard bench: two drivers (settle 2 / 8-bit count, settle 1 / 2-bit count)
// against a transaction model indexed by the cycle-by-cycle uo_out table.
module tb_alu_host_driver;
  localparam int UN = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst[2];
  logic       cmd_valid[2], rsp_ready[2];
  logic [3:0] cmd_a[2], cmd_b[2], cmd_sel[2];
  logic       cmd_ready[2], rsp_valid[2], busy[2];
  logic [3:0] rsp_result[2], rsp_flags[2];
  logic [7:0] pin_ui[2], pin_uio[2], pin_oe[2], pin_uo[2], cmd_count[2];
  logic [7:0] uo_tab[2][UN];

  // reference model state
  logic [7:0] expq[2][$];
  bit         m_busy[2];
  int         m_tv[2], m_cnt[2];
  logic [7:0] m_ui[2], m_uio[2], m_oe[2];
  int n_chk = 0, n_fail = 0;

  function automatic int settle(int d); return (d == 0) ? 2 : 1; endfunction
  function automatic int cnt_mod(int d); return (d == 0) ? 256 : 4; endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle monitor: compares DUT against model, then advances the model
  // for the edge about to happen.
  task automatic mon(int d);
    logic       exp_v;
    logic [7:0] e;
    string      p;
    p = $sformatf("d%0d ", d);
    if (rst[d]) begin
      m_busy[d] = 0; m_cnt[d] = 0; m_ui[d] = 0; m_uio[d] = 0; m_oe[d] = 0;
      expq[d].delete();
    end
    exp_v = m_busy[d] && (cyc >= m_tv[d]);
    chk({p, "cmd_ready"}, 32'(cmd_ready[d]), 32'(!m_busy[d]));
    chk({p, "busy"},      32'(busy[d]),      32'(m_busy[d]));
    chk({p, "rsp_valid"}, 32'(rsp_valid[d]), 32'(exp_v));
    chk({p, "pin_ui"},    32'(pin_ui[d]),    32'(m_ui[d]));
    chk({p, "pin_uio"},   32'(pin_uio[d]),   32'(m_uio[d]));
    chk({p, "pin_oe"},    32'(pin_oe[d]),    32'(m_oe[d]));
    chk({p, "cmd_count"}, 32'(cmd_count[d]), 32'(m_cnt[d]));
    if (exp_v) begin
      chk({p, "rsp_pending"}, 32'(expq[d].size()), 32'(1));
      if (expq[d].size() != 0)
        chk({p, "rsp_data"}, 32'({rsp_flags[d], rsp_result[d]}), 32'(expq[d][0]));
    end else if (rst[d]) begin
      chk({p, "rsp_reset"}, 32'({rsp_flags[d], rsp_result[d]}), 32'(0));
    end
    if (!rst[d]) begin
      if (exp_v && rsp_ready[d]) begin
        if (expq[d].size() != 0) e = expq[d].pop_front();
        m_busy[d] = 0;
        m_cnt[d]  = (m_cnt[d] + 1) % cnt_mod(d);
      end else if (!m_busy[d] && cmd_valid[d]) begin
        expq[d].push_back(uo_tab[d][(cyc + settle(d)) % UN]);
        m_tv[d]   = cyc + settle(d) + 1;
        m_busy[d] = 1;
        m_ui[d]   = {cmd_b[d], cmd_a[d]};
        m_uio[d]  = {4'h0, cmd_sel[d]};
      end
      m_oe[d] = 8'h0F;
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int S  = (g == 0) ? 2 : 1;
    localparam int CW = (g == 0) ? 8 : 2;
    alu_host_driver_if bus ();
    logic [CW-1:0] cnt;
    assign bus.cmd_valid  = cmd_valid[g];
    assign bus.cmd_a      = cmd_a[g];
    assign bus.cmd_b      = cmd_b[g];
    assign bus.cmd_sel    = cmd_sel[g];
    assign bus.rsp_ready  = rsp_ready[g];
    assign cmd_ready[g]   = bus.cmd_ready;
    assign rsp_valid[g]   = bus.rsp_valid;
    assign rsp_result[g]  = bus.rsp_result;
    assign rsp_flags[g]   = bus.rsp_flags;
    assign cmd_count[g]   = 8'(cnt);
    assign pin_uo[g]      = uo_tab[g][cyc % UN];
    alu_host_driver #(.SETTLE_CYCLES(S), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst[g]), .host(bus),
      .pin_ui_out(pin_ui[g]), .pin_uio_out(pin_uio[g]), .pin_uio_oe(pin_oe[g]),
      .pin_uo_in(pin_uo[g]), .busy(busy[g]), .cmd_count(cnt));
    always @(negedge clk) mon(g);
  end

  task automatic step(); @(posedge clk); #1; endtask

  task automatic offer(int d, logic [3:0] a, logic [3:0] b, logic [3:0] s);
    cmd_a[d] = a; cmd_b[d] = b; cmd_sel[d] = s; cmd_valid[d] = 1'b1;
  endtask

  task automatic wait_hs(int d, bit rnd_ready);
    bit hs = 0;
    for (int i = 0; i < 200 && !hs; i++) begin
      @(negedge clk);
      hs = cmd_ready[d];
      step();
      if (rnd_ready) rsp_ready[d] = ($urandom_range(0, 2) != 0);
    end
    chk($sformatf("d%0d hs_timeout", d), 32'(hs), 32'(1));
    cmd_valid[d] = 1'b0;
  endtask

  task automatic send(int d, logic [3:0] a, logic [3:0] b, logic [3:0] s);
    offer(d, a, b, s);
    wait_hs(d, 0);
  endtask

  task automatic wait_rsp(int d);
    for (int i = 0; i < 300 && !rsp_valid[d]; i++) step();
    chk($sformatf("d%0d rsp_timeout", d), 32'(rsp_valid[d]), 32'(1));
  endtask

  task automatic wait_idle(int d);
    for (int i = 0; i < 300 && busy[d]; i++) step();
    chk($sformatf("d%0d idle_timeout", d), 32'(busy[d]), 32'(0));
  endtask

  task automatic rand_run(int d);
    repeat (30) begin
      repeat ($urandom_range(0, 3)) begin
        rsp_ready[d] = ($urandom_range(0, 2) != 0);
        step();
      end
      offer(d, 4'($urandom), 4'($urandom), 4'($urandom));
      wait_hs(d, 1);
    end
    rsp_ready[d] = 1'b1;
    wait_idle(d);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  hs_t[4];
    int  n;
    bit  hs;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < UN; i++) uo_tab[d][i] = 8'($urandom);
      rst[d] = 1'b1; cmd_valid[d] = 1'b0; rsp_ready[d] = 1'b0;
      cmd_a[d] = '0; cmd_b[d] = '0; cmd_sel[d] = '0;
      m_busy[d] = 0; m_tv[d] = 0; m_cnt[d] = 0; m_ui[d] = 0; m_uio[d] = 0; m_oe[d] = 0;
    end
    repeat (3) step();
    rst[0] = 1'b0; rst[1] = 1'b0;
    #1 chk("d0 oe_before_edge", 32'(pin_oe[0]), 32'h00);
    step();
    chk("d0 oe_after_edge", 32'(pin_oe[0]), 32'h0F);

    // single operation, settle 2
    for (int i = 0; i < 60; i++) uo_tab[0][(cyc + i) % UN] = 8'h48;
    rsp_ready[0] = 1'b1;
    send(0, 4'd3, 4'd5, 4'h2);
    chk("d0 pin_ui_op", 32'(pin_ui[0]), 32'h53);
    chk("d0 pin_uio_op", 32'(pin_uio[0]), 32'h02);
    step();
    chk("d0 lat_early", 32'(rsp_valid[0]), 32'(0));
    step();
    chk("d0 lat_exact", 32'(rsp_valid[0]), 32'(1));
    chk("d0 result", 32'(rsp_result[0]), 32'h8);
    chk("d0 flags", 32'(rsp_flags[0]), 32'h4);
    step();
    chk("d0 count_1", 32'(cmd_count[0]), 32'(1));
    chk("d0 ready_after", 32'(cmd_ready[0]), 32'(1));

    // backpressure with changing uo_out and a blocked new command
    rsp_ready[0] = 1'b0;
    send(0, 4'd3, 4'd5, 4'h2);
    wait_rsp(0);
    for (int i = 0; i < 20; i++) uo_tab[0][(cyc + i) % UN] = 8'hFF;
    offer(0, 4'hE, 4'hA, 4'h7);
    repeat (5) begin
      step();
      chk("d0 bp_result", 32'(rsp_result[0]), 32'h8);
      chk("d0 bp_flags", 32'(rsp_flags[0]), 32'h4);
      chk("d0 bp_pin_ui", 32'(pin_ui[0]), 32'h53);
    end
    rsp_ready[0] = 1'b1;
    wait_hs(0, 0);
    wait_idle(0);

    // async reset mid-SETTLE
    send(0, 4'h9, 4'h6, 4'h1);
    #1 rst[0] = 1'b1;
    #1;
    chk("d0 rst_settle_busy", 32'(busy[0]), 32'(0));
    chk("d0 rst_settle_ui", 32'(pin_ui[0]), 32'h00);
    chk("d0 rst_settle_uio", 32'(pin_uio[0]), 32'h00);
    chk("d0 rst_settle_oe", 32'(pin_oe[0]), 32'h00);
    chk("d0 rst_settle_cnt", 32'(cmd_count[0]), 32'(0));
    step(); rst[0] = 1'b0;
    repeat (6) step();
    chk("d0 no_rsp_after_rst", 32'(rsp_valid[0]), 32'(0));

    // async reset mid-RESP
    rsp_ready[0] = 1'b0;
    send(0, 4'h1, 4'h2, 4'h3);
    wait_rsp(0);
    #1 rst[0] = 1'b1;
    #1;
    chk("d0 rst_resp_valid", 32'(rsp_valid[0]), 32'(0));
    chk("d0 rst_resp_data", 32'({rsp_flags[0], rsp_result[0]}), 32'h00);
    step(); rst[0] = 1'b0; rsp_ready[0] = 1'b1;
    repeat (6) step();
    chk("d0 no_rsp_after_rst2", 32'(rsp_valid[0]), 32'(0));
    chk("d0 cnt_after_rst2", 32'(cmd_count[0]), 32'(0));

    // back-to-back with cmd_valid held high
    n = 0;
    offer(0, 4'($urandom), 4'($urandom), 4'($urandom));
    for (int i = 0; i < 100 && n < 4; i++) begin
      @(negedge clk);
      hs = cmd_ready[0];
      if (hs) hs_t[n] = cyc;
      step();
      if (hs) begin
        n++;
        cmd_a[0] = 4'($urandom); cmd_b[0] = 4'($urandom); cmd_sel[0] = 4'($urandom);
      end
    end
    cmd_valid[0] = 1'b0;
    chk("d0 b2b_handshakes", 32'(n), 32'(4));
    for (int k = 1; k < 4; k++) chk("d0 b2b_spacing", 32'(hs_t[k] - hs_t[k-1]), 32'(4));
    wait_idle(0);
    chk("d0 b2b_count", 32'(cmd_count[0]), 32'(4));

    // sample point, settle 1
    rsp_ready[1] = 1'b1;
    uo_tab[1][cyc % UN] = 8'h11;
    uo_tab[1][(cyc + 1) % UN] = 8'hA7;
    send(1, 4'h2, 4'h4, 4'h6);
    step();
    chk("d1 sp_valid", 32'(rsp_valid[1]), 32'(1));
    chk("d1 sp_result", 32'(rsp_result[1]), 32'h7);
    chk("d1 sp_flags", 32'(rsp_flags[1]), 32'hA);
    wait_idle(1);

    // counter wrap, 2-bit count
    rst[1] = 1'b1; step(); rst[1] = 1'b0; step();
    repeat (5) begin
      send(1, 4'($urandom), 4'($urandom), 4'($urandom));
      wait_idle(1);
    end
    chk("d1 wrap_count", 32'(cmd_count[1]), 32'(1));

    fork
      rand_run(0);
      rand_run(1);
    join
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_host_driver.md
Name: alu_host_driver

Overview:
Host-side driver for the 4-bit ALU Tiny Tapeout pin interface. It accepts an operation command (A, B, select) on a valid/ready port and drives the ALU's ui_in/uio_in pins. After a programmable settle time it samples the ALU's uo_out pins and returns the result and flags on a valid/ready response port. It sits on the test/host board side or in a wrapping SoC, facing the ALU macro's pins.

Parameters:
SETTLE_CYCLES, 2, clock edges from the command handshake to uo_out sampling; legal range 1..255.
CNT_W, 8, width of the completed-operation counter.

Ports:
clk  input  1  single clock; all logic rising-edge.
rst  input  1  reset, asynchronous, active-high.
cmd_valid  input  1  command offered.
cmd_ready  output  1  driver can accept a command.
cmd_a  input  4  operand A.
cmd_b  input  4  operand B.
cmd_sel  input  4  ALU select code, passed through unchanged.
rsp_valid  output  1  response available.
rsp_ready  input  1  consumer accepts response.
rsp_result  output  4  sampled uo_out[3:0].
rsp_flags  output  4  sampled uo_out[7:4] = {carry, zero, negative, overflow}.
pin_ui_out  output  8  to ALU ui_in = {B, A}.
pin_uio_out  output  8  to ALU uio_in = {4'b0000, sel}.
pin_uio_oe  output  8  output enables for uio pins.
pin_uo_in  input  8  from ALU uo_out.
busy  output  1  high whenever the state is not IDLE.
cmd_count  output  CNT_W  number of completed operations; wraps.

Behaviour:
- Reset (async assert, any state): state=IDLE; rsp_valid=0; rsp_result=0; rsp_flags=0; pin_ui_out=0x00; pin_uio_out=0x00; pin_uio_oe=0x00; cmd_count=0; settle counter=0. Any in-flight operation is dropped with no response.
- pin_uio_oe is registered. It becomes 0x0F on the first clock edge after reset deassertion and stays 0x0F. Bits [7:4] are always 0.
- cmd_ready is combinational: cmd_ready = (state==IDLE). busy = (state!=IDLE).
- FSM states: IDLE, SETTLE, RESP.
- IDLE: on an edge with cmd_valid&&cmd_ready:
  - register pin_ui_out={cmd_b,cmd_a} and pin_uio_out={4'b0,cmd_sel};
  - load settle counter with SETTLE_CYCLES-1;
  - go to SETTLE.
- SETTLE, counter!=0: decrement the counter each edge.
- SETTLE, counter==0: at that edge, capture rsp_result=pin_uo_in[3:0] and rsp_flags=pin_uo_in[7:4], set rsp_valid=1, go to RESP.
- Latency: rsp_valid rises exactly SETTLE_CYCLES edges after the command handshake edge. uo_out is sampled at that same edge.
- RESP: on an edge with rsp_valid&&rsp_ready: clear rsp_valid, increment cmd_count (modulo 2^CNT_W, so 2^CNT_W-1 wraps to 0), go to IDLE.
- While rsp_valid=1 and rsp_ready=0, rsp_result and rsp_flags hold stable.
- Pins hold the last driven operands after completion. They do not return to 0 until the next command or reset.
- cmd_valid outside IDLE is ignored (nothing latched). The source must hold the command per the valid/ready rules.
- rsp_ready outside RESP has no effect.
- Minimum command period is SETTLE_CYCLES+2 edges: handshake, settle, response accept, then IDLE.
- pin_uo_in changing during SETTLE is allowed. Only the value at the capture edge matters.
- Reset asserted during RESP: the pending response is lost and rsp_valid drops immediately (async).

Test Plan:
- Reset, then release: cmd_ready=1, busy=0, rsp_valid=0, all pin outputs 0x00, cmd_count=0. pin_uio_oe=0x0F one edge after release.
- Single operation, SETTLE_CYCLES=2: cmd A=3, B=5, sel=0x2; bench holds pin_uo_in=0x48.
  - pin_ui_out=0x53 and pin_uio_out=0x02 after the handshake edge.
  - rsp_valid rises exactly 2 edges after the handshake, with rsp_result=0x8 and rsp_flags=0x4.
  - With rsp_ready=1, cmd_count=1 and cmd_ready=1 on the next cycle.
- Backpressure: hold rsp_ready=0 for 5 cycles while pin_uo_in toggles 0x48→0xFF.
  - rsp_result/flags stay 0x8/0x4.
  - cmd_valid with new data is not accepted; pin_ui_out stays 0x53.
- Sample-point check, SETTLE_CYCLES=1: pin_uo_in=0x11 at the handshake edge and 0xA7 at the next edge → response 0x7/0xA.
- Back-to-back: 4 commands with cmd_valid held high and rsp_ready=1 → handshakes spaced exactly SETTLE_CYCLES+2 edges apart; cmd_count=4.
- Async reset asserted mid-SETTLE, and separately mid-RESP: outputs clear immediately, without waiting for a clock edge. No response appears after release. cmd_count=0. Wrap check with CNT_W=2: 5 completed operations → cmd_count=1.
